// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// divide sequencer state encoding and E-stage forward-select codes.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // E-stage operand select; M wins over W and $0 is never forwarded.
    function automatic logic [1:0] fwdSelE(
        input logic [4:0] src,
        input logic       regWriteM,
        input logic [4:0] writeRegM,
        input logic       regWriteW,
        input logic [4:0] writeRegW
    );
        if (regWriteM && src != 5'd0 && writeRegM == src)
            return FWD_M;
        else if (regWriteW && src != 5'd0 && writeRegW == src)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-register specifiers/control bits in, and the
// stall/flush/forward controls back out to the pipeline.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [4:0] RsD, RtD;
    logic       BranchD, PCSrcD;
    logic [4:0] RsE, RtE, WriteRegE;
    logic       RegWriteE, MemtoRegE, DivStartE;
    logic [4:0] WriteRegM;
    logic       RegWriteM, MemtoRegM;
    logic [4:0] WriteRegW;
    logic       RegWriteW;

    logic       stallF, stallD, stallE;
    logic       flushD, flushE, flushM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD;
    logic       div_busy, div_done;

    modport master (
        output RsD, RtD, BranchD, PCSrcD, RsE, RtE, WriteRegE,
               RegWriteE, MemtoRegE, DivStartE, WriteRegM, RegWriteM,
               MemtoRegM, WriteRegW, RegWriteW,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
               ForwardAE, ForwardBE, ForwardAD, ForwardBD, div_busy, div_done
    );

    modport slave (
        input  RsD, RtD, BranchD, PCSrcD, RsE, RtE, WriteRegE,
               RegWriteE, MemtoRegE, DivStartE, WriteRegM, RegWriteM,
               MemtoRegM, WriteRegW, RegWriteW,
        output stallF, stallD, stallE, flushD, flushE, flushM,
               ForwardAE, ForwardBE, ForwardAD, ForwardBD, div_busy, div_done
    );

endinterface

// File: rtl/hazard_ctrl_div_seq.sv
// Divide sequencer: freezes the front of the pipe for DIV_CYCLES cycles
// while the divider in E runs, then pulses divDone for one cycle.
module hazard_ctrl_div_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic divStartE,
    output logic dstall,
    output logic divBusy,
    output logic divDone
);

    divState_t          stateReg, stateNext;
    logic [CNT_W-1:0]   cntReg, cntNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    // The IDLE cycle that sees the divide already counts as a stall cycle,
    // so BUSY lasts DIV_CYCLES-1 cycles.
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        dstall    = 1'b0;
        divBusy   = 1'b0;
        divDone   = 1'b0;
        unique case (stateReg)
            IDLE: begin
                if (divStartE) begin
                    dstall    = 1'b1;
                    stateNext = BUSY;
                    cntNext   = CNT_W'(DIV_CYCLES - 2);
                end
            end
            BUSY: begin
                dstall  = 1'b1;
                divBusy = 1'b1;
                if (cntReg == '0)
                    stateNext = DONE;
                else
                    cntNext = cntReg - CNT_W'(1);
            end
            DONE: begin
                divDone   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/interlock controller for the 5-stage pipeline: forwarding selects,
// load-use and branch interlocks, taken-branch flush and divide freeze.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    logic dstall, lwstall, brstall, hazStall;
    logic divBusy, divDone;

    hazard_ctrl_div_seq #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_seq (
        .clk       (clk),
        .reset     (reset),
        .divStartE (hz.DivStartE),
        .dstall    (dstall),
        .divBusy   (divBusy),
        .divDone   (divDone)
    );

    always_comb begin
        hz.ForwardAE = fwdSelE(hz.RsE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
        hz.ForwardBE = fwdSelE(hz.RtE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
        hz.ForwardAD = hz.RegWriteM && hz.RsD != 5'd0 && hz.WriteRegM == hz.RsD;
        hz.ForwardBD = hz.RegWriteM && hz.RtD != 5'd0 && hz.WriteRegM == hz.RtD;
    end

    // A load result in M is not ready for the D-stage compare, so it stalls
    // rather than forwards; an ALU result in M is forwarded instead.
    always_comb begin
        lwstall = hz.MemtoRegE && hz.WriteRegE != 5'd0 &&
                  (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD);
        brstall = hz.BranchD &&
                  ((hz.RegWriteE && hz.WriteRegE != 5'd0 &&
                    (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
                   (hz.MemtoRegM && hz.WriteRegM != 5'd0 &&
                    (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
        hazStall = lwstall || brstall || dstall;
    end

    // A frozen E is never bubbled; M takes bubbles while E is held.
    always_comb begin
        hz.stallF   = hazStall;
        hz.stallD   = hazStall;
        hz.stallE   = dstall;
        hz.flushE   = (lwstall || brstall) && !dstall;
        hz.flushD   = hz.PCSrcD && !hazStall;
        hz.flushM   = dstall;
        hz.div_busy = divBusy;
        hz.div_done = divDone;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus
// hand-written divide and reset-mid-divide sequences.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        logic [4:0] rsD, rtD;
        logic       branchD, pcSrcD;
        logic [4:0] rsE, rtE, writeRegE;
        logic       regWriteE, memtoRegE;
        logic [4:0] writeRegM;
        logic       regWriteM, memtoRegM;
        logic [4:0] writeRegW;
        logic       regWriteW;
        logic [11:0] exp; // {stallF,stallD,stallE,flushD,flushE,flushM,FAE,FBE,FAD,FBD}
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string name,
        input logic [4:0] rsD, input logic [4:0] rtD, input logic branchD, input logic pcSrcD,
        input logic [4:0] rsE, input logic [4:0] rtE, input logic [4:0] writeRegE,
        input logic regWriteE, input logic memtoRegE,
        input logic [4:0] writeRegM, input logic regWriteM, input logic memtoRegM,
        input logic [4:0] writeRegW, input logic regWriteW,
        input logic [11:0] exp
    );
        vec_t v;
        v.name = name; v.rsD = rsD; v.rtD = rtD; v.branchD = branchD; v.pcSrcD = pcSrcD;
        v.rsE = rsE; v.rtE = rtE; v.writeRegE = writeRegE;
        v.regWriteE = regWriteE; v.memtoRegE = memtoRegE;
        v.writeRegM = writeRegM; v.regWriteM = regWriteM; v.memtoRegM = memtoRegM;
        v.writeRegW = writeRegW; v.regWriteW = regWriteW; v.exp = exp;
        return v;
    endfunction

    function automatic logic [11:0] combOuts();
        return {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.flushM,
                hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD};
    endfunction

    // {stallF,stallD,stallE,flushE,flushM,flushD,div_busy,div_done}
    function automatic logic [7:0] divOuts();
        return {hz.stallF, hz.stallD, hz.stallE, hz.flushE, hz.flushM, hz.flushD,
                hz.div_busy, hz.div_done};
    endfunction

    task automatic clearIn();
        hz.RsD = '0; hz.RtD = '0; hz.BranchD = 0; hz.PCSrcD = 0;
        hz.RsE = '0; hz.RtE = '0; hz.WriteRegE = '0; hz.RegWriteE = 0;
        hz.MemtoRegE = 0; hz.DivStartE = 0; hz.WriteRegM = '0; hz.RegWriteM = 0;
        hz.MemtoRegM = 0; hz.WriteRegW = '0; hz.RegWriteW = 0;
    endtask

    task automatic checkDiv(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = divOuts();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else
            $display("ok   %s: %b", name, act);
    endtask

    initial begin
        logic [11:0] act;
        logic [7:0]  divExp[7];

        clearIn();
        // name, rsD,rtD,brD,pcD, rsE,rtE,wrE,rwE,m2rE, wrM,rwM,m2rM, wrW,rwW, exp
        vecs.push_back(mk("idle_zero",     0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0, 12'b000000_00_00_0_0));
        vecs.push_back(mk("fwdAE_M_prio",  0,0,0,0, 5,0,0,0,0, 5,1,0, 5,1, 12'b000000_10_00_0_0));
        vecs.push_back(mk("fwdAE_W",       0,0,0,0, 5,0,0,0,0, 5,0,0, 5,1, 12'b000000_01_00_0_0));
        vecs.push_back(mk("fwdAE_r0",      0,0,0,0, 0,0,0,0,0, 0,1,0, 0,1, 12'b000000_00_00_0_0));
        vecs.push_back(mk("fwdBE_M",       0,0,0,0, 0,7,0,0,0, 7,1,0, 0,0, 12'b000000_00_10_0_0));
        vecs.push_back(mk("fwdBE_W",       0,0,0,0, 0,7,0,0,0, 7,0,0, 7,1, 12'b000000_00_01_0_0));
        vecs.push_back(mk("loaduse_rt",    0,8,0,0, 0,0,8,1,1, 0,0,0, 0,0, 12'b110010_00_00_0_0));
        vecs.push_back(mk("loaduse_clear", 0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0, 12'b000000_00_00_0_0));
        vecs.push_back(mk("load_r0",       0,0,0,0, 0,0,0,1,1, 0,0,0, 0,0, 12'b000000_00_00_0_0));
        vecs.push_back(mk("br_alu_E",      3,0,1,0, 0,0,3,1,0, 0,0,0, 0,0, 12'b110010_00_00_0_0));
        vecs.push_back(mk("br_fwd_M",      3,0,1,0, 0,0,0,0,0, 3,1,0, 0,0, 12'b000000_00_00_1_0));
        vecs.push_back(mk("br_load_M",     0,4,1,0, 0,0,0,0,0, 4,1,1, 0,0, 12'b110010_00_00_0_1));
        vecs.push_back(mk("taken_flushD",  0,0,0,1, 0,0,0,0,0, 0,0,0, 0,0, 12'b000100_00_00_0_0));
        vecs.push_back(mk("taken_lwstall", 8,0,0,1, 0,0,8,1,1, 0,0,0, 0,0, 12'b110010_00_00_0_0));
        vecs.push_back(mk("nobr_alu_E",    3,0,0,0, 0,0,3,1,0, 0,0,0, 0,0, 12'b000000_00_00_0_0));

        // Reset state
        #1;
        checkDiv("reset_state", 8'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            hz.RsD = vecs[i].rsD; hz.RtD = vecs[i].rtD; hz.BranchD = vecs[i].branchD;
            hz.PCSrcD = vecs[i].pcSrcD; hz.RsE = vecs[i].rsE; hz.RtE = vecs[i].rtE;
            hz.WriteRegE = vecs[i].writeRegE; hz.RegWriteE = vecs[i].regWriteE;
            hz.MemtoRegE = vecs[i].memtoRegE; hz.WriteRegM = vecs[i].writeRegM;
            hz.RegWriteM = vecs[i].regWriteM; hz.MemtoRegM = vecs[i].memtoRegM;
            hz.WriteRegW = vecs[i].writeRegW; hz.RegWriteW = vecs[i].regWriteW;
            #1;
            act = combOuts();
            checks++;
            if (act !== vecs[i].exp) begin
                failures++;
                $display("FAIL %s: got %b expected %b", vecs[i].name, act, vecs[i].exp);
            end else
                $display("ok   %s: %b", vecs[i].name, act);
        end

        // Divide with DIV_CYCLES=4: 4 stall cycles (IDLE + 3 BUSY), DONE, then idle.
        // A load-use hazard plus taken branch in cycle 2 must neither flush E nor D.
        divExp = '{8'b111_0_1_0_0_0, 8'b111_0_1_0_1_0, 8'b111_0_1_0_1_0,
                   8'b111_0_1_0_1_0, 8'b000_0_0_0_0_1, 8'b0, 8'b0};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            clearIn();
            hz.DivStartE = (c <= 4);
            if (c == 2) begin
                hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.WriteRegE = 5'd8;
                hz.RtD = 5'd8; hz.PCSrcD = 1;
            end
            #1;
            checkDiv($sformatf("div_cycle%0d", c), divExp[c]);
        end

        // Reset asserted in the 2nd BUSY cycle, between clock edges.
        @(negedge clk); clearIn(); hz.DivStartE = 1; #1; checkDiv("rst_div_start", 8'b111_0_1_0_0_0);
        @(negedge clk); #1; checkDiv("rst_busy1", 8'b111_0_1_0_1_0);
        @(negedge clk); #1; checkDiv("rst_busy2", 8'b111_0_1_0_1_0);
        #1;
        reset = 1'b1;
        hz.DivStartE = 0;
        #1;
        checkDiv("rst_async_drop", 8'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkDiv("rst_release", 8'b0);
        @(negedge clk); #1; checkDiv("rst_idle1", 8'b0);
        @(negedge clk); #1; checkDiv("rst_idle2", 8'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
